// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and controller state encoding.
// Defaults describe 640x480 @ 60 Hz with an 800 x 525 raster.
package vga_timing_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with terminal-count flag,
// registered active-low sync decode and a look-ahead active-window decode.
module timing_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic             sync,
    output logic             active_next
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    if (TOTAL > MAX_TOTAL) begin : g_total_check
        $error("timing_axis_counter: axis total %0d exceeds %0d", TOTAL, MAX_TOTAL);
    end

    localparam logic [CNT_W-1:0] LAST    = 10'(TOTAL - 1);
    localparam logic [CNT_W:0]   ACT_END = 11'(ACTIVE);
    localparam logic [CNT_W:0]   SYNC_LO = 11'(ACTIVE + FP);
    localparam logic [CNT_W:0]   SYNC_HI = 11'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   next_ext;
    logic             sync_next;

    always_comb begin
        tc = (count == LAST);
        count_next = count;
        if (start)
            count_next = '0;
        else if (step)
            count_next = tc ? '0 : count + 10'd1;
        next_ext    = {1'b0, count_next};
        // Decode the upcoming position so the registered outputs line up with count.
        active_next = (next_ext < ACT_END);
        sync_next   = !((next_ext >= SYNC_LO) && (next_ext < SYNC_HI));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= 1'b1;
        end else begin
            count <= count_next;
            sync  <= sync_next;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: IDLE until the first enabled edge, then free-running
// x/y scan with registered sync, active and strobe outputs plus a frame counter.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    state_t state;
    logic   start, adv, wrap;
    logic   h_tc, v_tc, h_act_nx, v_act_nx;

    assign start = (state == IDLE) && ena;
    assign adv   = (state == RUN) && ena;
    assign wrap  = adv && h_tc && v_tc;

    timing_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .step       (adv),
        .count      (x),
        .tc         (h_tc),
        .sync       (hsync),
        .active_next(h_act_nx)
    );

    timing_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .step       (adv && h_tc),
        .count      (y),
        .tc         (v_tc),
        .sync       (vsync),
        .active_next(v_act_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            if (start)
                state <= RUN;
            line_start  <= start || (adv && h_tc);
            frame_start <= start || wrap;
            // frame_active holds through disabled cycles and stays low while idle.
            if (start || adv)
                frame_active <= h_act_nx && v_act_nx;
            if (wrap)
                frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default-timing instance for line/sync/enable behaviour and a
// small-raster instance (15 x 11) for frame length, frame counter wrap and async reset.
module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic rst_n, ena_d, ena_s;

    logic [9:0] dx, dy, sx, sy;
    logic       dfa, dhs, dvs, dls, dfs;
    logic       sfa, shs, svs, sls, sfs;
    logic [7:0] dfc, sfc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_generator u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena_d),
        .x(dx), .y(dy), .frame_active(dfa), .hsync(dhs), .vsync(dvs),
        .line_start(dls), .frame_start(dfs), .frame_count(dfc)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .ena(ena_s),
        .x(sx), .y(sy), .frame_active(sfa), .hsync(shs), .vsync(svs),
        .line_start(sls), .frame_start(sfs), .frame_count(sfc)
    );

    task automatic test_reset();
        rst_n = 1'b0; ena_d = 1'b1; ena_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dx, dy, dfa, dhs, dvs, dls, dfs, dfc} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_default got x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want 0 0 0 1 1 0 0 0",
                     dx, dy, dfa, dhs, dvs, dls, dfs, dfc);
        end
        checks++;
        if ({sx, sy, sfa, shs, svs, sls, sfs, sfc} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_small got x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want 0 0 0 1 1 0 0 0",
                     sx, sy, sfa, shs, svs, sls, sfs, sfc);
        end
        ena_d = 1'b0; ena_s = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dx, dfa, dls, dfs, dhs} !== {10'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL idle_hold got x=%0d fa=%b ls=%b fs=%b hs=%b want 0 0 0 0 1", dx, dfa, dls, dfs, dhs);
        end
    endtask

    task automatic test_start();
        ena_d = 1'b1;
        @(negedge clk);
        checks++;
        if ({dx, dy, dfa, dhs, dvs, dls, dfs, dfc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL first_edge got x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want 0 0 1 1 1 1 1 0",
                     dx, dy, dfa, dhs, dvs, dls, dfs, dfc);
        end
        @(negedge clk);
        checks++;
        if ({dx, dy, dfa, dls, dfs} !== {10'd1, 10'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL second_edge got x=%0d y=%0d fa=%b ls=%b fs=%b want 1 0 1 0 0", dx, dy, dfa, dls, dfs);
        end
    endtask

    task automatic test_line();
        int ex = 1, ey = 0;
        int pos_bad = 0, fa_bad = 0, ls_bad = 0, hs_low = 0, hs_first = -1, fa_low = 0;
        bit done = 0;
        for (int i = 0; i < 900 && !done; i++) begin
            @(negedge clk);
            if (ex == 799) begin ex = 0; ey++; end else ex++;
            if (dx !== 10'(ex) || dy !== 10'(ey)) pos_bad++;
            if (dfa !== ((ex < 640) && (ey < 480))) fa_bad++;
            if (!dfa) fa_low++;
            if (dhs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(dx);
            end
            if (dls !== (ex == 0)) ls_bad++;
            if (ex == 0) done = 1;
        end
        checks++;
        if (!done || pos_bad != 0) begin
            errors++;
            $display("FAIL line_position got mismatches=%0d done=%0d want 0 1", pos_bad, done);
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL line_hsync_width got %0d want 96", hs_low);
        end
        checks++;
        if (hs_first != 656) begin
            errors++;
            $display("FAIL line_hsync_start got %0d want 656", hs_first);
        end
        checks++;
        if (fa_bad != 0 || fa_low != 160) begin
            errors++;
            $display("FAIL line_frame_active got bad=%0d low=%0d want 0 160", fa_bad, fa_low);
        end
        checks++;
        if (ls_bad != 0 || dy !== 10'd1 || dls !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap got ls_bad=%0d y=%0d ls=%b want 0 1 1", ls_bad, dy, dls);
        end
    endtask

    task automatic test_toggle();
        int ex = 0, ey = 0;
        bit started = 0;
        int pos_bad = 0, strobe_bad = 0, en_low = 0, all_low = 0, hs_bad = 0;
        rst_n = 1'b0; ena_d = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ena_d = (i % 2 == 0);
            @(negedge clk);
            if (ena_d) begin
                if (!started) begin started = 1; ex = 0; ey = 0; end
                else if (ex == 799) begin ex = 0; ey++; end
                else ex++;
            end
            if (dx !== 10'(ex) || dy !== 10'(ey)) pos_bad++;
            if (dhs !== !((ex >= 656) && (ex < 752))) hs_bad++;
            if (!ena_d && (dls || dfs)) strobe_bad++;
            if (ena_d && dhs === 1'b0) en_low++;
            if (dhs === 1'b0) all_low++;
        end
        ena_d = 1'b0;
        checks++;
        if (pos_bad != 0 || hs_bad != 0) begin
            errors++;
            $display("FAIL toggle_position got pos_bad=%0d hs_bad=%0d want 0 0", pos_bad, hs_bad);
        end
        checks++;
        if (strobe_bad != 0) begin
            errors++;
            $display("FAIL toggle_strobe got %0d want 0", strobe_bad);
        end
        checks++;
        if (en_low != 96 || all_low != 192) begin
            errors++;
            $display("FAIL toggle_hsync_span got en=%0d all=%0d want 96 192", en_low, all_low);
        end
        checks++;
        if (dx !== 10'd199 || dy !== 10'd1) begin
            errors++;
            $display("FAIL toggle_final got x=%0d y=%0d want 199 1", dx, dy);
        end
    endtask

    task automatic test_frame();
        int cyc = 0, vlow = 0, vfx = -1, vfy = -1;
        bit done = 0;
        ena_d = 1'b0; ena_s = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ena_s = 1'b1;
        @(negedge clk);
        checks++;
        if ({sx, sy, sfs, sls, sfa, sfc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL frame_first got x=%0d y=%0d fs=%b ls=%b fa=%b fc=%0d want 0 0 1 1 1 0",
                     sx, sy, sfs, sls, sfa, sfc);
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (svs === 1'b0) begin
                vlow++;
                if (vfx < 0) begin vfx = int'(sx); vfy = int'(sy); end
            end
            if (sfs === 1'b1) done = 1;
        end
        checks++;
        if (!done || cyc != 165) begin
            errors++;
            $display("FAIL frame_period got %0d done=%0d want 165 1", cyc, done);
        end
        checks++;
        if (vlow != 30 || vfx != 0 || vfy != 7) begin
            errors++;
            $display("FAIL frame_vsync got len=%0d at (%0d,%0d) want 30 at (0,7)", vlow, vfx, vfy);
        end
        checks++;
        if (sfc !== 8'd1 || sx !== 10'd0 || sy !== 10'd0) begin
            errors++;
            $display("FAIL frame_count_inc got fc=%0d x=%0d y=%0d want 1 0 0", sfc, sx, sy);
        end
    endtask

    task automatic test_wrap();
        int px = 0, py = 0, pfc = 1, inc_bad = 0, incs = 0;
        bit done = 0;
        for (int i = 0; i < 50000 && !done; i++) begin
            px = int'(sx); py = int'(sy); pfc = int'(sfc);
            @(negedge clk);
            if (int'(sfc) != pfc) begin
                incs++;
                if (!(px == 14 && py == 10 && int'(sfc) == ((pfc + 1) % 256))) inc_bad++;
                if (sfc == 8'd0) done = 1;
            end
        end
        checks++;
        if (!done || incs != 255 || inc_bad != 0) begin
            errors++;
            $display("FAIL wrap_sequence got done=%0d incs=%0d bad=%0d want 1 255 0", done, incs, inc_bad);
        end
        checks++;
        if (px != 14 || py != 10 || pfc != 255) begin
            errors++;
            $display("FAIL wrap_before got (%0d,%0d) fc=%0d want (14,10) 255", px, py, pfc);
        end
        checks++;
        if (sx !== 10'd0 || sy !== 10'd0 || sfs !== 1'b1 || sfc !== 8'd0) begin
            errors++;
            $display("FAIL wrap_after got (%0d,%0d) fs=%b fc=%0d want (0,0) 1 0", sx, sy, sfs, sfc);
        end
    endtask

    task automatic test_async_reset();
        repeat (215) @(negedge clk);
        checks++;
        if ({sx, sy, sfa, sfc} !== {10'd5, 10'd3, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL areset_pre got (%0d,%0d) fa=%b fc=%0d want (5,3) 1 1", sx, sy, sfa, sfc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sx, sy, sfa, shs, svs, sls, sfs, sfc} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL areset_immediate got (%0d,%0d) fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want (0,0) 0 1 1 0 0 0",
                     sx, sy, sfa, shs, svs, sls, sfs, sfc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({sx, sy, sfa, sls, sfs, sfc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL areset_restart got (%0d,%0d) fa=%b ls=%b fs=%b fc=%0d want (0,0) 1 1 1 0",
                     sx, sy, sfa, sls, sfs, sfc);
        end
        @(negedge clk);
        checks++;
        if (sx !== 10'd1 || sfs !== 1'b0) begin
            errors++;
            $display("FAIL areset_advance got x=%0d fs=%b want 1 0", sx, sfs);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena_d = 1'b0; ena_s = 1'b0;
        test_reset();
        test_start();
        test_line();
        test_toggle();
        test_frame();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
